// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bundles the TDM word stream into the demultiplexer and the
// lane outputs coming back from it.
//   in_valid     word/frame_start valid this cycle
//   in_data      slot word (W bits)
//   frame_start  marks slot 0, qualified by in_valid
//   out_data     N_CH lanes of W bits, lane k = out_data[k*W +: W]
//   out_valid    per-lane one-cycle update strobe
//   frame_done   one-cycle pulse when a full frame has been delivered
//   sync_err     one-cycle pulse on a frame-alignment error
// master = stream source / lane consumer, slave = the demultiplexer.
interface tdm_demux_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    logic                in_valid;
    logic [W-1:0]        in_data;
    logic                frame_start;
    logic [N_CH*W-1:0]   out_data;
    logic [N_CH-1:0]     out_valid;
    logic                frame_done;
    logic                sync_err;

    modport master (
        output in_valid, in_data, frame_start,
        input  out_data, out_valid, frame_done, sync_err
    );

    modport slave (
        input  in_valid, in_data, frame_start,
        output out_data, out_valid, frame_done, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the channel-multiplexing path. Splits a TDM word
// stream (one word per slot, N_CH slots per frame, slot 0 flagged by
// frame_start) into N_CH registered lanes with a per-lane update strobe,
// flags frame-alignment errors and resynchronises on them.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   tdm_demux_if slave modport (stream in, lanes/strobes out)
module tdm_demux #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    tdm_demux_if.slave    bus
);
    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   slot, slot_n;

    logic            wr_en;
    logic [SW-1:0]   wr_lane;
    logic            done_n;
    logic            err_n;

    logic [N_CH*W-1:0] lane_q;
    logic [N_CH-1:0]   valid_q;
    logic              done_q;
    logic              err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
        end
    end

    // Next-state logic; in_valid=0 is a stall and leaves everything as is.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        if (bus.in_valid) begin
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        state_n = RUN;
                        slot_n  = SW'(1);
                    end
                end
                RUN: begin
                    if (bus.frame_start) begin
                        slot_n = SW'(1);
                    end else if (slot == '0) begin
                        // Expected a frame start and did not get one: lose lock.
                        state_n = IDLE;
                        slot_n  = '0;
                    end else if (slot == LAST) begin
                        slot_n = '0;
                    end else begin
                        slot_n = slot + SW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    slot_n  = '0;
                end
            endcase
        end
    end

    // Output decode: which lane this word lands in and which strobes fire.
    always_comb begin
        wr_en   = 1'b0;
        wr_lane = '0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (bus.in_valid) begin
            case (state)
                IDLE: begin
                    wr_en = bus.frame_start;
                end
                RUN: begin
                    if (bus.frame_start) begin
                        wr_en = 1'b1;
                        err_n = (slot != '0);   // premature frame start
                    end else if (slot == '0) begin
                        err_n = 1'b1;           // missing frame start, word dropped
                    end else begin
                        wr_en   = 1'b1;
                        wr_lane = slot;
                        done_n  = (slot == LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered lanes and strobes: one stage between accept and output.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                valid_q[k] <= wr_en && (wr_lane == SW'(k));
                if (wr_en && (wr_lane == SW'(k)))
                    lane_q[k*W +: W] <= bus.in_data;
            end
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign bus.out_data   = lane_q;
    assign bus.out_valid  = valid_q;
    assign bus.frame_done = done_q;
    assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;
    localparam int N_CH = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_demux_if #(.N_CH(N_CH), .W(W)) bus();

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pos = words received into the current frame
    // (1..N_CH), or -1 while hunting for a frame start.
    logic [W-1:0] exp_lane [N_CH];
    int           pos = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
        int               lane;
        logic             e_done, e_err;
        logic [N_CH-1:0]  e_valid;
        logic [N_CH*W-1:0] e_data;

        rst             = r;
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.in_data     = d;
        @(posedge clk);
        #1;

        lane   = -1;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (r) begin
            for (int k = 0; k < N_CH; k++) exp_lane[k] = '0;
            pos = -1;
        end else if (v) begin
            if (fs) begin
                if (pos > 0 && pos < N_CH) e_err = 1'b1;
                lane = 0;
                pos  = 1;
            end else if (pos == -1) begin
                lane = -1;
            end else if (pos == N_CH) begin
                e_err = 1'b1;
                pos   = -1;
            end else begin
                lane = pos;
                pos  = pos + 1;
                if (pos == N_CH) e_done = 1'b1;
            end
            if (lane >= 0) exp_lane[lane] = d;
        end

        e_valid = '0;
        if (lane >= 0) e_valid[lane] = 1'b1;
        for (int k = 0; k < N_CH; k++) e_data[k*W +: W] = exp_lane[k];

        check("out_data",   64'(bus.out_data),   64'(e_data));
        check("out_valid",  64'(bus.out_valid),  64'(e_valid));
        check("frame_done", 64'(bus.frame_done), 64'(e_done));
        check("sync_err",   64'(bus.sync_err),   64'(e_err));
    endtask

    initial begin
        logic [W-1:0] fr [4];
        logic         want, v, fs;

        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.in_data     = '0;
        for (int k = 0; k < N_CH; k++) exp_lane[k] = '0;

        // 1: reset, then idle
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);

        // 2: back-to-back frame
        fr[0] = 8'hA0; fr[1] = 8'hB1; fr[2] = 8'hC2; fr[3] = 8'hD3;
        for (int i = 0; i < 4; i++) step(0, 1, i == 0, fr[i]);

        // 3: same frame with gaps (stalls carry junk frame_start/data)
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i == 0, fr[i]);
            step(0, 0, 1, 8'hEE);
            if (i == 1) step(0, 0, 0, 8'h99);
        end

        // 4: premature frame start on the third word
        step(0, 1, 1, 8'h11);
        step(0, 1, 0, 8'h22);
        step(0, 1, 1, 8'hE0);
        step(0, 1, 0, 8'hE1);
        step(0, 1, 0, 8'hE2);
        step(0, 1, 0, 8'hE3);

        // 5: missing frame start after complete frame, then hunting
        step(0, 1, 0, 8'h55);
        step(0, 1, 0, 8'h66);
        step(0, 0, 0, 8'h00);
        step(0, 1, 0, 8'h77);
        for (int i = 0; i < 4; i++) step(0, 1, i == 0, 8'(8'h30 + i));

        // 6: reset mid-frame, then a fresh frame
        step(0, 1, 1, 8'h5A);
        step(0, 1, 0, 8'h5B);
        step(1, 1, 0, 8'h5C);
        step(0, 1, 0, 8'h5D);
        for (int i = 0; i < 4; i++) step(0, 1, i == 0, 8'(8'hC0 + i));

        // N_CH=2 style short frame error after frame_start at slot 0 boundary
        step(0, 1, 1, 8'h01);
        step(0, 1, 1, 8'h02);

        // Randomized traffic, mostly well-formed with occasional faults
        for (int i = 0; i < 3000; i++) begin
            want = (pos == -1) || (pos == N_CH);
            v    = ($urandom_range(0, 3) != 0);
            fs   = want ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 199) == 0, v, fs, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
